shift_add_multiplier: RTL and testbench

//  Iterative shift-and-add unsigned multiplier; supersedes the fixed combinational x10 multiplier.

---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/shift_add_step.sv | 22 ++
 rtl/shift_add_multiplier.sv | 146 ++++++++++++++
 tb/tb_shift_add_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t   : FSM encoding (IDLE=0, RUN=1, DONE=2; the unused code 3 falls back to IDLE)
//   cnt_width : width of the step counter, wide enough to hold WIDTH-1 without wrapping
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// Single combinational shift-and-add step, shared with the planned radix-4 variant.
//   acc, mcand  : 2*WIDTH-bit partial product and shifted multiplicand
//   mplier      : WIDTH-bit remaining multiplier; its LSB selects the add
//   *_next      : values after one step (conditional add, mcand << 1, mplier >> 1)
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // The product of two WIDTH-bit operands always fits in 2*WIDTH bits,
    // so the accumulate can never carry out.
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier with valid/ready on both sides.
// Fixed latency of WIDTH cycles from accept to outValid, regardless of operands.
//   clk, reset          : clock, asynchronous active-high reset
//   inValid/inReady     : input handshake (inReady high only in IDLE)
//   inputSignal, factor : WIDTH-bit unsigned operands (factor used only if USE_PORT_FACTOR=1)
//   outValid/outReady   : output handshake (outValid high only in DONE)
//   result, overflow    : exact 2*WIDTH-bit product and "upper half non-zero" flag
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEFAULT_FACTOR  = 10,
    parameter bit USE_PORT_FACTOR = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   inputSignal,
    input  logic [WIDTH-1:0]   factor,
    output logic               outValid,
    input  logic               outReady,
    output logic [2*WIDTH-1:0] result,
    output logic               overflow
);

    localparam int               PW         = 2 * WIDTH;
    localparam int               CW         = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] DEF_FACTOR = WIDTH'(DEFAULT_FACTOR);
    localparam logic [CW-1:0]    LAST_CNT   = CW'(WIDTH - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     mcand_reg;
    logic [WIDTH-1:0]  mplier_reg;
    logic [CW-1:0]     cnt_reg;
    logic [PW-1:0]     result_reg;
    logic              overflow_reg;

    logic [PW-1:0]     acc_step;
    logic [PW-1:0]     mcand_step;
    logic [WIDTH-1:0]  mplier_step;
    logic [WIDTH-1:0]  factor_sel;

    // Multiplier source is fixed at elaboration time.
    generate
        if (USE_PORT_FACTOR) begin : g_port_factor
            assign factor_sel = factor;
        end else begin : g_default_factor
            logic unused_factor;
            assign unused_factor = ^factor;
            assign factor_sel    = DEF_FACTOR;
        end
    endgenerate

    shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc_reg),
        .mcand       (mcand_reg),
        .mplier      (mplier_reg),
        .acc_next    (acc_step),
        .mcand_next  (mcand_step),
        .mplier_next (mplier_step)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        inReady    = 1'b0;
        outValid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // No early exit: every operation takes exactly WIDTH steps.
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (inValid) begin
                        acc_reg    <= '0;
                        mcand_reg  <= {{WIDTH{1'b0}}, inputSignal};
                        mplier_reg <= factor_sel;
                        cnt_reg    <= '0;
                    end
                end
                ST_RUN: begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_step;
                    mplier_reg <= mplier_step;
                    cnt_reg    <= cnt_reg + CW'(1);
                    // The final step's add is folded straight into the result.
                    if (cnt_reg == LAST_CNT) begin
                        result_reg   <= acc_step;
                        overflow_reg <= |acc_step[PW-1:WIDTH];
                    end
                end
                default: begin
                    // DONE holds result/overflow until the consumer takes them.
                end
            endcase
        end
    end

    assign result   = result_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: three instances
//   0: WIDTH=32, fixed factor 10   1: WIDTH=32, port factor   2: WIDTH=4, port factor
// Expected products come from plain multiplication in the bench.
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic        out_ready [3];
    logic [31:0] in_sig    [3];
    logic [31:0] fac       [3];
    wire         in_ready  [3];
    wire         out_valid [3];
    wire         ovf       [3];
    wire  [63:0] res       [3];

    wire         rdy_a, rdy_b, rdy_c, val_a, val_b, val_c, ovf_a, ovf_b, ovf_c;
    wire  [63:0] res_a, res_b;
    wire  [7:0]  res_c;

    assign in_ready[0]  = rdy_a;  assign in_ready[1]  = rdy_b;  assign in_ready[2]  = rdy_c;
    assign out_valid[0] = val_a;  assign out_valid[1] = val_b;  assign out_valid[2] = val_c;
    assign ovf[0]       = ovf_a;  assign ovf[1]       = ovf_b;  assign ovf[2]       = ovf_c;
    assign res[0]       = res_a;  assign res[1]       = res_b;  assign res[2]       = {56'd0, res_c};

    shift_add_multiplier #(.WIDTH(32), .DEFAULT_FACTOR(10), .USE_PORT_FACTOR(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .inValid(in_valid[0]), .inReady(rdy_a),
        .inputSignal(in_sig[0]), .factor(fac[0]), .outValid(val_a), .outReady(out_ready[0]),
        .result(res_a), .overflow(ovf_a));

    shift_add_multiplier #(.WIDTH(32), .DEFAULT_FACTOR(10), .USE_PORT_FACTOR(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .inValid(in_valid[1]), .inReady(rdy_b),
        .inputSignal(in_sig[1]), .factor(fac[1]), .outValid(val_b), .outReady(out_ready[1]),
        .result(res_b), .overflow(ovf_b));

    shift_add_multiplier #(.WIDTH(4), .DEFAULT_FACTOR(10), .USE_PORT_FACTOR(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .inValid(in_valid[2]), .inReady(rdy_c),
        .inputSignal(in_sig[2][3:0]), .factor(fac[2][3:0]), .outValid(val_c), .outReady(out_ready[2]),
        .result(res_c), .overflow(ovf_c));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One accept/compute/deliver transaction on instance k.
    // hold: cycles to keep outReady low in DONE; poke: pulse inValid with junk during RUN/DONE.
    task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] f,
                          input int hold, input bit poke,
                          output logic [63:0] got, output logic got_ovf);
        int          w;
        int          n;
        logic [63:0] exp;
        logic        exp_ovf;
        w       = (k == 2) ? 4 : 32;
        exp     = (k == 0) ? (64'(x) * 64'd10) : (64'(x) * 64'(f));
        exp_ovf = (k == 2) ? (exp[7:4] != 4'd0) : (exp[63:32] != 32'd0);

        n = 0;
        while (!in_ready[k] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", {63'd0, in_ready[k]}, 64'd1);

        in_sig[k]   = x;
        fac[k]      = f;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        // Operands change right after accept; the DUT must have captured them.
        in_valid[k] = 1'b0;
        in_sig[k]   = $urandom;
        fac[k]      = $urandom;
        chk("in_ready_after_accept", {63'd0, in_ready[k]}, 64'd0);

        n = 0;
        while (!out_valid[k] && n < 200) begin
            in_valid[k] = poke;
            @(posedge clk); #1; n++;
        end
        in_valid[k] = 1'b0;
        chk("latency", 64'(n), 64'(w));
        chk("result", res[k], exp);
        chk("overflow", {63'd0, ovf[k]}, {63'd0, exp_ovf});
        got     = res[k];
        got_ovf = ovf[k];

        repeat (hold) begin
            in_valid[k] = poke;
            in_sig[k]   = $urandom;
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid[k]}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready[k]}, 64'd0);
            chk("bp_result", res[k], exp);
        end
        in_valid[k] = 1'b0;

        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("release_out_valid", {63'd0, out_valid[k]}, 64'd0);
        chk("release_in_ready", {63'd0, in_ready[k]}, 64'd1);
        $display("op dut%0d: %h * %h -> %h ovf=%0d", k, x, (k == 0) ? 32'd10 : f, got, got_ovf);
    endtask

    // Per-cycle invariants: handshakes exclusive, result stable under backpressure.
    logic        pv   [3];
    logic        pr   [3];
    logic [63:0] pres [3];
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                chk("ready_valid_exclusive", {63'd0, in_ready[k] & out_valid[k]}, 64'd0);
                if (out_valid[k] && pv[k] && !pr[k]) begin
                    chk("hold_stable", res[k], pres[k]);
                end
            end
            pv[k]   = out_valid[k];
            pr[k]   = out_ready[k];
            pres[k] = res[k];
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] got;
        logic        got_ovf;
        logic [31:0] x;
        logic [31:0] f;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_sig[k] = '0; fac[k] = '0;
            pv[k] = 1'b0; pr[k] = 1'b0; pres[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", {63'd0, in_ready[k]}, 64'd1);
            chk("reset_out_valid", {63'd0, out_valid[k]}, 64'd0);
            chk("reset_result", res[k], 64'd0);
            chk("reset_overflow", {63'd0, ovf[k]}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fixed factor 10, factor port ignored.
        run_op(0, 32'h111, $urandom, 0, 1'b0, got, got_ovf);
        chk("pin_0x111_x10", got, 64'hAAA);
        chk("pin_0x111_ovf", {63'd0, got_ovf}, 64'd0);
        run_op(0, 32'h1999_999A, $urandom, 0, 1'b0, got, got_ovf);
        chk("pin_x10_overflow_val", got, 64'h1_0000_0004);
        chk("pin_x10_overflow_flag", {63'd0, got_ovf}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            x = 32'h111 * $urandom_range(0, 32'h0FFF_FFFF / 32'h111);
            run_op(0, x, $urandom, i % 3, 1'b0, got, got_ovf);
        end
        run_op(0, 32'h0, $urandom, 0, 1'b0, got, got_ovf);

        // Port factor: extremes, random, backpressure with ignored pulses.
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got, got_ovf);
        chk("pin_max_sq", got, 64'hFFFF_FFFE_0000_0001);
        chk("pin_max_sq_ovf", {63'd0, got_ovf}, 64'd1);
        run_op(1, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, got, got_ovf);
        chk("pin_zero_x_max", got, 64'd0);
        chk("pin_zero_ovf", {63'd0, got_ovf}, 64'd0);
        run_op(1, 32'h1234_5678, 32'h0, 0, 1'b0, got, got_ovf);
        run_op(1, $urandom, $urandom, 10, 1'b1, got, got_ovf);
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            f = (i % 4 == 0) ? $urandom_range(0, 255) : $urandom;
            run_op(1, x, f, $urandom_range(0, 3), (i % 5 == 0), got, got_ovf);
        end

        // Asynchronous reset five cycles into RUN.
        in_sig[1] = 32'd123; fac[1] = 32'd456; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid[1]}, 64'd0);
        chk("async_rst_result", res[1], 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready[1]}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op(1, 32'd7, 32'd6, 0, 1'b0, got, got_ovf);
        chk("pin_7x6", got, 64'd42);

        // WIDTH=4 exhaustive.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(2, 32'(a), 32'(b), 0, 1'b0, got, got_ovf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
